// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the fetch and MEM stages,
// freezing the whole pipeline until every access demanded in the current step has been served.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IRdata,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUresultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallPipe,
  output logic              BusErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, DBUSY, IBUSY} state_t;
  state_t state, nextState;
  logic dDone, iDone, dPend, iPend, issueD, issueI, timedOut, finish;
  logic [7:0] waitCnt;
  logic [DATA_W-1:0] word;
  assign dPend = (MemtoRegM | MemWriteM) & ~dDone;
  assign iPend = IReq & ~iDone;
  assign StallPipe = dPend | iPend;
  assign timedOut = waitCnt == 8'(TIMEOUT - 1);
  assign finish = (state != IDLE) & (mem_ack | timedOut);
  // data access outranks fetch: it belongs to the older instruction
  assign issueD = (state == IDLE) & dPend;
  assign issueI = (state == IDLE) & ~dPend & iPend;
  assign word = mem_ack ? mem_rdata : '0;
  always_comb begin
    nextState = issueD ? DBUSY : issueI ? IBUSY : finish ? IDLE : state;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= nextState;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      IRdata    <= '0;
      ReadDataM <= '0;
      BusErr    <= 1'b0;
      waitCnt   <= 8'd0;
      dDone     <= 1'b0;
      iDone     <= 1'b0;
    end else begin
      if (issueD | issueI) begin
        mem_req  <= 1'b1;
        mem_we   <= issueD & MemWriteM;
        mem_addr <= issueD ? ALUresultM : IAddr;
      end else if (finish) mem_req <= 1'b0;
      if (issueD) mem_wdata <= WriteDataM;
      if (finish & (state == DBUSY) & ~mem_we) ReadDataM <= word;
      if (finish & (state == IBUSY)) IRdata <= word;
      if (finish & ~mem_ack) BusErr <= 1'b1;
      waitCnt <= ((state != IDLE) & ~finish) ? waitCnt + 8'd1 : 8'd0;
      // done flags survive only while the pipeline is still frozen
      dDone <= StallPipe & (dDone | (finish & (state == DBUSY)));
      iDone <= StallPipe & (iDone | (finish & (state == IBUSY)));
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed stimulus for mem_port_arbiter, checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 4;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic IReq = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0, mem_ack = 1'b0;
  logic [31:0] IAddr = '0, ALUresultM = '0, WriteDataM = '0, mem_rdata = '0;
  logic [31:0] IRdata, ReadDataM, mem_addr, mem_wdata;
  logic StallPipe, BusErr, mem_req, mem_we;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUresultM(ALUresultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallPipe(StallPipe),
    .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0;
  // model: one outstanding access, its kind and age, plus which stages are served this step
  logic mOut, mKindD, mDServed, mIServed, advanced;
  int mAge;
  logic eReq, eWe, eBusErr;
  logic [31:0] eAddr, eWdata, eIR, eRD;
  // memory responder and observation counters
  int rCnt = 0, rN = 1, forcedN = 0, stallCnt, reqCnt, issues;
  logic [31:0] fixData = '0;
  logic prevReq = 1'b0;
  logic [31:0] issAddr[4], issWdata[4];
  logic issWe[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic expStall();
    return ((MemtoRegM | MemWriteM) & ~mDServed) | (IReq & ~mIServed);
  endfunction

  task automatic modelReset();
    mOut = 0; mKindD = 0; mDServed = 0; mIServed = 0; advanced = 0; mAge = 0;
    eReq = 0; eWe = 0; eBusErr = 0; eAddr = '0; eWdata = '0; eIR = '0; eRD = '0;
  endtask

  task automatic modelEdge();
    logic pre;
    logic [31:0] w;
    if (!RST_N) begin
      modelReset();
      return;
    end
    pre = expStall();
    if (mOut) begin
      mAge++;
      if (mem_ack || mAge == TIMEOUT) begin
        w = mem_ack ? mem_rdata : 32'h0;
        eBusErr |= !mem_ack;
        if (mKindD) begin
          if (!eWe) eRD = w;
          mDServed = 1;
        end else begin
          eIR = w;
          mIServed = 1;
        end
        eReq = 0;
        mOut = 0;
      end
    end else if ((MemtoRegM | MemWriteM) && !mDServed) begin
      mOut = 1; mKindD = 1; mAge = 0; eReq = 1;
      eWe = MemWriteM; eAddr = ALUresultM; eWdata = WriteDataM;
    end else if (IReq && !mIServed) begin
      mOut = 1; mKindD = 0; mAge = 0; eReq = 1; eWe = 0; eAddr = IAddr;
    end
    if (!pre) begin
      mDServed = 0;
      mIServed = 0;
    end
    advanced = !pre;
  endtask

  task automatic respond();
    if (!RST_N || !mem_req) begin
      rCnt = 0;
      mem_ack = 0;
    end else begin
      rCnt++;
      if (rCnt == 1) rN = forcedN != 0 ? forcedN : $urandom_range(1, 6);
      mem_ack = rCnt == rN;
    end
    mem_rdata = (mem_ack && forcedN != 0) ?
                (fixData != 0 ? fixData : {16'hA5A5, mem_addr[15:0]}) : $urandom;
  endtask

  task automatic compareAll();
    check("StallPipe", StallPipe, expStall());
    check("mem_req", mem_req, eReq);
    check("BusErr", BusErr, eBusErr);
    check("IRdata", IRdata, eIR);
    check("ReadDataM", ReadDataM, eRD);
    if (eReq) begin
      check("mem_we", mem_we, eWe);
      check("mem_addr", mem_addr, eAddr);
      if (eWe) check("mem_wdata", mem_wdata, eWdata);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    compareAll();
    stallCnt += int'(StallPipe);
    reqCnt += int'(mem_req);
    if (mem_req && !prevReq) begin
      if (issues < 4) begin
        issAddr[issues] = mem_addr;
        issWe[issues] = mem_we;
        issWdata[issues] = mem_wdata;
      end
      issues++;
    end
    prevReq = mem_req;
    @(posedge CLK);
    modelEdge();
    #1;
    respond();
  endtask

  task automatic runTxn(input int n, input logic [31:0] data);
    int c;
    forcedN = n; fixData = data; stallCnt = 0; reqCnt = 0; issues = 0; c = 0;
    do begin
      step();
      c++;
    end while (!advanced && c < 60);
    check("txn-completes", advanced, 1);
    IReq = 0; MemtoRegM = 0; MemWriteM = 0;
    step();
    step();
  endtask

  task automatic randomInputs();
    int sel;
    sel = $urandom_range(0, 3);
    IReq = $urandom_range(0, 3) != 0;
    MemtoRegM = sel[0];
    MemWriteM = sel[1];
    IAddr = $urandom; ALUresultM = $urandom; WriteDataM = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    modelReset();
    step();
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst IRdata", IRdata, 0);
    check("rst ReadDataM", ReadDataM, 0);
    check("rst BusErr", BusErr, 0);
    check("rst StallPipe", StallPipe, 0);
    RST_N = 1;
    // single fetch, one-cycle latency
    IReq = 1; IAddr = 32'h40;
    runTxn(1, 32'h8C080004);
    check("t1 stall cycles", stallCnt, 2);
    check("t1 req cycles", reqCnt, 1);
    check("t1 issues", issues, 1);
    check("t1 addr", issAddr[0], 32'h40);
    check("t1 IRdata", IRdata, 32'h8C080004);
    check("t1 model IR", eIR, 32'h8C080004);
    // load and fetch both pending, three-cycle latency each
    MemtoRegM = 1; ALUresultM = 32'h100; IReq = 1; IAddr = 32'h44;
    runTxn(3, 0);
    check("t2 stall cycles", stallCnt, 8);
    check("t2 issues", issues, 2);
    check("t2 first addr", issAddr[0], 32'h100);
    check("t2 first we", issWe[0], 0);
    check("t2 second addr", issAddr[1], 32'h44);
    check("t2 ReadDataM", ReadDataM, 32'hA5A50100);
    check("t2 IRdata", IRdata, 32'hA5A50044);
    check("t2 model RD", eRD, 32'hA5A50100);
    // store leaves the held load word alone
    MemWriteM = 1; ALUresultM = 32'h200; WriteDataM = 32'hDEADBEEF;
    runTxn(2, 0);
    check("t3 stall cycles", stallCnt, 3);
    check("t3 issues", issues, 1);
    check("t3 we", issWe[0], 1);
    check("t3 addr", issAddr[0], 32'h200);
    check("t3 wdata", issWdata[0], 32'hDEADBEEF);
    check("t3 ReadDataM", ReadDataM, 32'hA5A50100);
    // load and store flags together mean a write
    MemtoRegM = 1; MemWriteM = 1; ALUresultM = 32'h300; WriteDataM = 32'h12345678;
    runTxn(1, 0);
    check("t4 we", issWe[0], 1);
    check("t4 wdata", issWdata[0], 32'h12345678);
    check("t4 ReadDataM", ReadDataM, 32'hA5A50100);
    // ack arriving on the timeout edge wins
    MemtoRegM = 1; ALUresultM = 32'h500;
    runTxn(TIMEOUT, 0);
    check("t5 stall cycles", stallCnt, TIMEOUT + 1);
    check("t5 req cycles", reqCnt, TIMEOUT);
    check("t5 ReadDataM", ReadDataM, 32'hA5A50500);
    check("t5 BusErr", BusErr, 0);
    // ack never arrives
    MemtoRegM = 1; ALUresultM = 32'h400;
    runTxn(255, 0);
    check("t6 stall cycles", stallCnt, TIMEOUT + 1);
    check("t6 req cycles", reqCnt, TIMEOUT);
    check("t6 ReadDataM", ReadDataM, 0);
    check("t6 BusErr", BusErr, 1);
    check("t6 model BusErr", eBusErr, 1);
    for (int i = 0; i < 5; i++) step();
    check("t6 BusErr sticky", BusErr, 1);
    // reset in the middle of a data access
    MemtoRegM = 1; ALUresultM = 32'h600; forcedN = 3; fixData = 0;
    step();
    step();
    check("t7 busy before reset", mem_req, 1);
    RST_N = 0;
    modelReset();
    #1;
    check("t7 req dropped", mem_req, 0);
    check("t7 BusErr cleared", BusErr, 0);
    step();
    RST_N = 1;
    runTxn(3, 0);
    check("t7 reissue count", issues, 1);
    check("t7 reissue addr", issAddr[0], 32'h600);
    check("t7 ReadDataM", ReadDataM, 32'hA5A50600);
    // randomized pipeline traffic with random latencies, including timeouts and resets
    forcedN = 0; fixData = 0;
    randomInputs();
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 249) == 0) begin
        RST_N = 0;
        modelReset();
        step();
        RST_N = 1;
      end
      if (advanced) randomInputs();
      else if ($urandom_range(0, 3) == 0) begin
        IAddr = $urandom; ALUresultM = $urandom; WriteDataM = $urandom;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
